gate_preact_mac: RTL and testbench

Serial multiply-accumulate stage that computes one gate pre-activation, sum(w_i * x_i) + b, in Q(QN).(QM) fixed point. It sits directly upstream of the piecewise-quadratic sigmoid gate and feeds that gate's `operand` input. It holds the result stable under a valid/ready handshake for the gate's two-cycle evaluation.

---
 rtl/gate_preact_mac.sv | 80 ++++++++
 tb/tb_gate_preact_mac.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/gate_preact_mac.sv
// gate_preact_mac: serial MAC producing one Q(QN).(QM) gate pre-activation, sum(w*x)+b, held under valid/ready.
// Optional feature: define GATE_PREACT_SAT_EN to saturate the result instead of wrapping it.
module gate_preact_mac #(
    parameter int QN    = 6,
    parameter int QM    = 11,
    parameter int NELEM = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [QN+QM:0]   weight,
    input  logic [QN+QM:0]   data,
    input  logic [QN+QM:0]   bias,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [QN+QM:0]   result
);
    localparam int W    = QN + QM + 1;
    localparam int CW   = NELEM > 1 ? $clog2(NELEM) : 1;
    localparam int ACCW = 2 * W + $clog2(NELEM) + 1;

    typedef enum logic [1:0] {ACCUM, FINAL, OUT} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          count;
    logic signed [2*W-1:0]  prod;
    logic signed [ACCW-1:0] acc, prod_ext, sum, scaled;
    logic [W-1:0]           bias_q, result_nxt;
    logic                   xfer, last;

    assign prod     = $signed(weight) * $signed(data);
    assign prod_ext = {{(ACCW-2*W){prod[2*W-1]}}, prod};
    assign sum      = acc + ({{(ACCW-W){bias_q[W-1]}}, bias_q} << QM);
    assign scaled   = sum >>> QM;
    assign xfer     = in_valid && in_ready;
    assign last     = count == CW'(NELEM - 1);

`ifdef GATE_PREACT_SAT_EN
    logic ovf_pos, ovf_neg;
    assign ovf_pos    = !scaled[ACCW-1] && |scaled[ACCW-2:W-1];
    assign ovf_neg    = scaled[ACCW-1] && !(&scaled[ACCW-2:W-1]);
    assign result_nxt = ovf_pos ? {1'b0, {(W-1){1'b1}}} :
                        ovf_neg ? {1'b1, {(W-1){1'b0}}} : W'(scaled);
`else
    assign result_nxt = W'(scaled);
`endif

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ACCUM;
        else        state <= state_nxt;
    end

    // Next state and handshake outputs; in_ready is forced low while reset is held.
    always_comb begin
        in_ready  = reset && state == ACCUM;
        out_valid = state == OUT;
        state_nxt = state == ACCUM ? (xfer && last ? FINAL : ACCUM) :
                    state == FINAL ? OUT :
                    (out_ready ? ACCUM : OUT);
    end

    // Accumulate beats (first beat of a frame reloads acc and bias), then scale once in FINAL.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            acc    <= '0;
            bias_q <= '0;
            result <= '0;
        end else begin
            if (xfer) begin
                acc    <= count == '0 ? prod_ext : acc + prod_ext;
                bias_q <= count == '0 ? bias : bias_q;
                count  <= last ? '0 : count + CW'(1);
            end
            if (state == FINAL) result <= result_nxt;
        end
    end
endmodule

// File: tb/tb_gate_preact_mac.sv
// tb_gate_preact_mac: scoreboard bench for gate_preact_mac with NELEM=4.
module tb_gate_preact_mac;
    localparam int QN = 6, QM = 11, NELEM = 4, W = 18;

    logic         clk = 0, reset = 0, in_valid = 0, out_ready = 1;
    logic         in_ready, out_valid;
    logic [W-1:0] weight = 0, data = 0, bias = 0, result, popped;
    logic [W-1:0] exp_q[$];
    int           n_chk = 0, n_pass = 0;

    gate_preact_mac #(.QN(QN), .QM(QM), .NELEM(NELEM)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .weight(weight), .data(data), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] model(input logic [3:0][W-1:0] w, input logic [3:0][W-1:0] d, input logic [W-1:0] b);
        longint s = longint'($signed(b)) <<< QM;
        for (int i = 0; i < NELEM; i++) s += longint'($signed(w[i])) * longint'($signed(d[i]));
        s = s >>> QM;
`ifdef GATE_PREACT_SAT_EN
        if (s > 131071) return 18'h1FFFF;
        if (s < -131072) return 18'h20000;
`endif
        return s[W-1:0];
    endfunction

    // Drives one frame; skip bit k low-> valid in cycle k. Bias is corrupted after the first beat.
    task automatic send(input logic [3:0][W-1:0] w, input logic [3:0][W-1:0] d, input logic [W-1:0] b,
                        input logic [15:0] skip, output int cycles);
        int  i = 0;
        logic took;
        cycles = 0;
        exp_q.push_back(model(w, d, b));
        while (i < NELEM && cycles < 64) begin
            in_valid = cycles < 16 ? !skip[cycles] : 1'b1;
            weight   = w[i];
            data     = d[i];
            bias     = i == 0 ? b : ~b;
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk); #1;
            cycles++;
            if (took) i++;
        end
        in_valid = 0;
        if (i < NELEM) check("accept_timeout", 32'(i), 32'(NELEM));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", 32'(exp_q.size()), 32'd1);
            else begin
                popped = exp_q.pop_front();
                check("result", 32'(result), 32'(popped));
            end
        end
    end

    initial begin
        int cyc, n;
        logic [3:0][W-1:0] rw, rd;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        @(negedge clk) reset = 1;
        @(posedge clk); #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        send({4{18'd2048}}, {4{18'd1024}}, 18'd512, 16'h0, cyc);
        check("final_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("out_valid_lat", 32'(out_valid), 32'd1);
        check("basic_result", 32'(result), 32'd4608);
        @(posedge clk); #1;
        check("back_in_ready", 32'(in_ready), 32'd1);
        check("back_out_valid", 32'(out_valid), 32'd0);

        send({4{18'd63488}}, {4{18'd63488}}, 18'd0, 16'h0, cyc);
        wait_ready();
        send({4{18'h30800}}, {4{18'd63488}}, 18'd0, 16'h0, cyc);
        wait_ready();
        send({18'd0, 18'd0, 18'd0, 18'd1}, {18'd0, 18'd0, 18'd0, 18'h3FFFF}, 18'd0, 16'h0, cyc);
        wait_ready();
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) begin
                rw[j] = W'($urandom);
                rd[j] = W'($urandom);
            end
            send(rw, rd, W'($urandom), 16'h0, cyc);
            wait_ready();
        end

        send({4{18'd2048}}, {4{18'd1024}}, 18'd512, 16'h0026, cyc);
        check("bubble_cycles", 32'(cyc), 32'd7);
        wait_ready();

        out_ready = 0;
        send({4{18'd2048}}, {4{18'd3072}}, 18'h3FE00, 16'h0, cyc);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_reach_out", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            if (exp_q.size() > 0) check("bp_result", 32'(result), 32'(exp_q[0]));
        end
        out_ready = 1;
        @(posedge clk); #1;
        check("bp_release_ov", 32'(out_valid), 32'd0);
        check("bp_release_ir", 32'(in_ready), 32'd1);

        in_valid = 1; weight = 18'd2048; data = 18'd2048; bias = 18'd0;
        repeat (2) @(posedge clk);
        #1 in_valid = 0;
        #2 reset = 0;
        #1;
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_ov", 32'(out_valid), 32'd0);
        check("mid_rst_ir", 32'(in_ready), 32'd0);
        #1 reset = 1;
        @(posedge clk); #1;
        send({4{18'd2048}}, {4{18'd1024}}, 18'd512, 16'h0, cyc);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
